// File: rtl/seq_chaser_pkg.sv
// Shared types and limits for the LED chaser: pattern modes, sequencer states
// and the legal parameter ranges checked at elaboration.
package seq_chaser_pkg;

    typedef enum logic [1:0] {
        CHASE_R = 2'd0,
        CHASE_L = 2'd1,
        BOUNCE  = 2'd2,
        FILL    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2
    } state_e;

    localparam int MIN_LEDS     = 2;
    localparam int MAX_LEDS     = 32;
    localparam int MIN_TICK_DIV = 1;
    localparam int MAX_TICK_DIV = 1 << 24;

endpackage

// File: rtl/seq_chaser_if.sv
// Control and status bundle of the LED chaser. The master side chooses run/pause,
// pattern and speed; the slave side (the chaser) returns the LED pattern and pulses.
interface seq_chaser_if
    import seq_chaser_pkg::*;
#(
    parameter int NUM_LEDS = 5
);
    logic                enable;
    mode_e               mode;
    logic [1:0]          speed;
    logic [NUM_LEDS-1:0] leds;
    logic                step_tick;
    logic                wrap;

    modport master (
        output enable, mode, speed,
        input  leds, step_tick, wrap
    );

    modport slave (
        input  enable, mode, speed,
        output leds, step_tick, wrap
    );
endinterface

// File: rtl/seq_chaser_prescaler.sv
// Step-rate prescaler: counts enabled cycles and flags the last cycle of each
// step period (TICK_DIV << speed). A count already past a newly shortened period
// ends the period immediately instead of running out of range.
module chaser_prescaler #(
    parameter int TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] speed,
    output logic       tick
);
    localparam int CNT_W = $clog2(TICK_DIV * 8) + 1;
    localparam logic [CNT_W-1:0] BASE = CNT_W'(TICK_DIV);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] period_m1;

    // Tick on the last count of the period; pausing holds the count where it is.
    always_comb begin
        period_m1 = (BASE << speed) - CNT_W'(1);
        tick      = enable && (count_q >= period_m1);
        count_d   = count_q;
        if (enable) begin
            count_d = tick ? '0 : count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/seq_chaser.sv
// LED chaser top: a prescaler paces a small BLANK/UP/DOWN sequencer whose
// state and position are decoded into one of four LED patterns. All outputs
// are registered and change on the edge that consumes a tick.
module seq_chaser
    import seq_chaser_pkg::*;
#(
    parameter int NUM_LEDS = 5,
    parameter int TICK_DIV = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    seq_chaser_if.slave bus
);
    localparam int POS_W = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    if (NUM_LEDS < MIN_LEDS || NUM_LEDS > MAX_LEDS) begin : g_bad_num_leds
        $error("seq_chaser: NUM_LEDS must lie in 2..32");
    end
    if (TICK_DIV < MIN_TICK_DIV || TICK_DIV > MAX_TICK_DIV) begin : g_bad_tick_div
        $error("seq_chaser: TICK_DIV must lie in 1..2^24");
    end

    logic                tick;
    state_e              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    mode_e               mode_q, mode_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                step_tick_q, step_tick_d;
    logic                wrap_q, wrap_d;

    chaser_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .speed  (bus.speed),
        .tick   (tick)
    );

    function automatic logic [NUM_LEDS-1:0] decode(mode_e m, state_e s, logic [POS_W-1:0] p);
        logic [NUM_LEDS-1:0] r;
        r = '0;
        if (s != BLANK) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                case (m)
                    CHASE_L: r[i] = (i == NUM_LEDS - 1 - int'(p));
                    FILL:    r[i] = (i <= int'(p));
                    default: r[i] = (i == int'(p));
                endcase
            end
        end
        return r;
    endfunction

    // Next step on a tick: a mode change blanks first, otherwise walk the pattern.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        mode_d      = mode_q;
        leds_d      = leds_q;
        step_tick_d = 1'b0;
        wrap_d      = 1'b0;
        if (tick) begin
            step_tick_d = 1'b1;
            mode_d      = bus.mode;
            if (bus.mode != mode_q) begin
                state_d = BLANK;
                pos_d   = '0;
            end else begin
                unique case (state_q)
                    BLANK: begin
                        state_d = UP;
                        pos_d   = '0;
                    end
                    UP: begin
                        if (pos_q != POS_LAST) begin
                            pos_d = pos_q + POS_ONE;
                        end else if (mode_q == BOUNCE) begin
                            state_d = DOWN;
                            pos_d   = POS_LAST - POS_ONE;
                            wrap_d  = (POS_LAST == POS_ONE);
                        end else begin
                            state_d = BLANK;
                            pos_d   = '0;
                            wrap_d  = 1'b1;
                        end
                    end
                    DOWN: begin
                        if (pos_q == '0) begin
                            state_d = UP;
                            pos_d   = POS_ONE;
                        end else begin
                            pos_d  = pos_q - POS_ONE;
                            wrap_d = (pos_q == POS_ONE);
                        end
                    end
                    default: begin
                        state_d = BLANK;
                        pos_d   = '0;
                    end
                endcase
            end
            leds_d = decode(mode_d, state_d, pos_d);
        end
    end

    // Sequencer and output registers; reset overrides enable and any pending tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BLANK;
            pos_q       <= '0;
            mode_q      <= CHASE_R;
            leds_q      <= '0;
            step_tick_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            mode_q      <= mode_d;
            leds_q      <= leds_d;
            step_tick_q <= step_tick_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bus.leds      = leds_q;
    assign bus.step_tick = step_tick_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_seq_chaser.sv
// Self-checking bench for seq_chaser with NUM_LEDS=5, TICK_DIV=4. A reference
// model walks each pattern as an index into a cyclic list of positions and is
// compared with the DUT every cycle, next to fixed expected sequences.
module tb_seq_chaser;
    import seq_chaser_pkg::*;

    localparam int N   = 5;
    localparam int DIV = 4;

    typedef struct {
        int       count;
        int       mode;
        logic     blank;
        int       idx;
        logic [N-1:0] leds;
        logic     step;
        logic     wrap;
    } model_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    model_t m;
    int     numChecks = 0;
    int     numErrors = 0;

    seq_chaser_if #(.NUM_LEDS(N)) bus ();

    seq_chaser #(
        .NUM_LEDS (N),
        .TICK_DIV (DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int seqLen(int md);
        return (md == 2) ? 2 * N - 2 : N + 1;
    endfunction

    // Chase/fill lists are positions 0..N-1 then a blank slot (idx N);
    // the bounce list is 0..N-1 followed by N-2..1.
    function automatic logic [N-1:0] patternAt(int md, int idx);
        logic [N-1:0] one;
        int pos;
        one = 1;
        if (md == 2) begin
            pos = (idx < N) ? idx : 2 * N - 2 - idx;
            return one << pos;
        end
        if (idx == N) return '0;
        case (md)
            1:       return one << (N - 1 - idx);
            3:       return (one << (idx + 1)) - one;
            default: return one << idx;
        endcase
    endfunction

    function automatic model_t modelStep(model_t cur, logic rst, logic en, int md, int spd);
        model_t nxt;
        int period;
        nxt      = cur;
        nxt.step = 1'b0;
        nxt.wrap = 1'b0;
        if (rst) begin
            nxt.count = 0;
            nxt.mode  = 0;
            nxt.blank = 1'b1;
            nxt.idx   = 0;
            nxt.leds  = '0;
            return nxt;
        end
        if (!en) return nxt;
        period = DIV << spd;
        if (cur.count < period - 1) begin
            nxt.count = cur.count + 1;
            return nxt;
        end
        nxt.count = 0;
        nxt.step  = 1'b1;
        if (md != cur.mode) begin
            nxt.mode  = md;
            nxt.blank = 1'b1;
            nxt.leds  = '0;
            return nxt;
        end
        if (cur.blank) begin
            nxt.blank = 1'b0;
            nxt.idx   = 0;
        end else begin
            nxt.idx  = (cur.idx + 1) % seqLen(md);
            nxt.wrap = (md == 2) ? (nxt.idx == 0) : (nxt.idx == N);
        end
        nxt.leds = patternAt(md, nxt.idx);
        return nxt;
    endfunction

    // Reference model advances on the same edge as the DUT from the same inputs.
    always @(posedge clk) begin
        m <= modelStep(m, reset, bus.enable, int'(bus.mode), int'(bus.speed));
    end

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        bus.mode   = FILL;
        bus.speed  = 2'd0;
        doReset();
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        numChecks++;
        if ({bus.leds, bus.step_tick, bus.wrap} !== 7'b0) begin
            numErrors++;
            $display("[TB] FAIL reset_outputs: got leds=%b step=%b wrap=%b, expected all 0",
                     bus.leds, bus.step_tick, bus.wrap);
        end
        repeat (3) begin
            @(negedge clk);
            numChecks++;
            if ({bus.leds, bus.step_tick, bus.wrap} !== 7'b0) begin
                numErrors++;
                $display("[TB] FAIL reset_hold: got leds=%b step=%b wrap=%b, expected all 0",
                         bus.leds, bus.step_tick, bus.wrap);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_patterns();
        logic [N-1:0] expq[$];
        logic [N-1:0] gotq[$];
        logic         wrapq[$];
        int           widx;
        mode_e        md;
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: begin md = CHASE_R; widx = 5; expq = {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000, 5'b00001}; end
                1: begin md = CHASE_L; widx = 6; expq = {5'b00000, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00000, 5'b10000}; end
                2: begin md = FILL;    widx = 6; expq = {5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000, 5'b00001}; end
                default: begin md = BOUNCE; widx = 9; expq = {5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00010}; end
            endcase
            bus.mode   = md;
            bus.speed  = 2'd0;
            bus.enable = 1'b1;
            doReset();
            gotq.delete();
            wrapq.delete();
            for (int c = 0; c < DIV * (expq.size() + 1); c++) begin
                @(negedge clk);
                numChecks++;
                if ({bus.leds, bus.step_tick, bus.wrap} !== {m.leds, m.step, m.wrap}) begin
                    numErrors++;
                    $display("[TB] FAIL model_%s: got leds=%b step=%b wrap=%b, expected leds=%b step=%b wrap=%b",
                             md.name(), bus.leds, bus.step_tick, bus.wrap, m.leds, m.step, m.wrap);
                end
                if (bus.step_tick) begin
                    gotq.push_back(bus.leds);
                    wrapq.push_back(bus.wrap);
                end
            end
            numChecks++;
            if (gotq.size() < expq.size()) begin
                numErrors++;
                $display("[TB] FAIL steps_%s: got %0d steps, expected at least %0d",
                         md.name(), gotq.size(), expq.size());
            end else begin
                for (int i = 0; i < expq.size(); i++) begin
                    numChecks++;
                    if (gotq[i] !== expq[i] || wrapq[i] !== (i == widx)) begin
                        numErrors++;
                        $display("[TB] FAIL seq_%s step %0d: got leds=%b wrap=%b, expected leds=%b wrap=%b",
                                 md.name(), i, gotq[i], wrapq[i], expq[i], (i == widx));
                    end
                end
            end
        end
    endtask

    task automatic test_speed();
        int gap;
        logic found;
        int expGap[4] = '{16, 16, 11, 4};
        bus.mode   = CHASE_R;
        bus.speed  = 2'd2;
        bus.enable = 1'b1;
        doReset();
        for (int k = 0; k < 4; k++) begin
            gap   = 0;
            found = 1'b0;
            while (!found && gap < 40) begin
                @(negedge clk);
                gap++;
                numChecks++;
                if ({bus.leds, bus.step_tick, bus.wrap} !== {m.leds, m.step, m.wrap}) begin
                    numErrors++;
                    $display("[TB] FAIL model_speed: got leds=%b step=%b wrap=%b, expected leds=%b step=%b wrap=%b",
                             bus.leds, bus.step_tick, bus.wrap, m.leds, m.step, m.wrap);
                end
                if (bus.step_tick) found = 1'b1;
                else if (k == 2 && gap == 10) bus.speed = 2'd0;
            end
            numChecks++;
            if (!found || gap != expGap[k]) begin
                numErrors++;
                $display("[TB] FAIL speed_gap %0d: got %0d cycles (seen=%b), expected %0d",
                         k, gap, found, expGap[k]);
            end
        end
    endtask

    task automatic test_pause();
        logic [N-1:0] frozen;
        int gap;
        logic found;
        bus.mode   = CHASE_R;
        bus.speed  = 2'd0;
        bus.enable = 1'b1;
        doReset();
        repeat (9) @(negedge clk);
        frozen     = bus.leds;
        bus.enable = 1'b0;
        numChecks++;
        if (frozen !== 5'b00010) begin
            numErrors++;
            $display("[TB] FAIL pause_start: got leds=%b, expected 00010", frozen);
        end
        repeat (20) begin
            @(negedge clk);
            numChecks++;
            if (bus.leds !== frozen || bus.step_tick !== 1'b0 || bus.wrap !== 1'b0) begin
                numErrors++;
                $display("[TB] FAIL paused: got leds=%b step=%b wrap=%b, expected leds=%b step=0 wrap=0",
                         bus.leds, bus.step_tick, bus.wrap, frozen);
            end
        end
        bus.enable = 1'b1;
        gap   = 0;
        found = 1'b0;
        while (!found && gap < 20) begin
            @(negedge clk);
            gap++;
            if (bus.step_tick) found = 1'b1;
        end
        numChecks++;
        if (!found || gap != DIV - (9 % DIV) || bus.leds !== 5'b00100) begin
            numErrors++;
            $display("[TB] FAIL resume: got gap=%0d leds=%b (seen=%b), expected gap=%0d leds=00100",
                     gap, bus.leds, found, DIV - (9 % DIV));
        end
    endtask

    task automatic test_mode_change_reset();
        logic [N-1:0] gotq[$];
        logic         wrapq[$];
        logic         found;
        logic [N-1:0] expAfter[3] = '{5'b00000, 5'b00001, 5'b00010};
        bus.mode   = CHASE_R;
        bus.speed  = 2'd0;
        bus.enable = 1'b1;
        doReset();
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (bus.step_tick && bus.leds === 5'b01000) found = 1'b1;
        end
        numChecks++;
        if (!found) begin
            numErrors++;
            $display("[TB] FAIL reach_pos3: got no 01000 step within 40 cycles, expected one");
        end
        bus.mode = BOUNCE;
        for (int c = 0; c < 3 * DIV; c++) begin
            @(negedge clk);
            numChecks++;
            if ({bus.leds, bus.step_tick, bus.wrap} !== {m.leds, m.step, m.wrap}) begin
                numErrors++;
                $display("[TB] FAIL model_modechange: got leds=%b step=%b wrap=%b, expected leds=%b step=%b wrap=%b",
                         bus.leds, bus.step_tick, bus.wrap, m.leds, m.step, m.wrap);
            end
            if (bus.step_tick) begin
                gotq.push_back(bus.leds);
                wrapq.push_back(bus.wrap);
            end
        end
        numChecks++;
        if (gotq.size() != 3) begin
            numErrors++;
            $display("[TB] FAIL modechange_steps: got %0d steps, expected 3", gotq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                numChecks++;
                if (gotq[i] !== expAfter[i] || wrapq[i] !== 1'b0) begin
                    numErrors++;
                    $display("[TB] FAIL modechange step %0d: got leds=%b wrap=%b, expected leds=%b wrap=0",
                             i, gotq[i], wrapq[i], expAfter[i]);
                end
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        numChecks++;
        if ({bus.leds, bus.step_tick, bus.wrap} !== 7'b0) begin
            numErrors++;
            $display("[TB] FAIL midreset: got leds=%b step=%b wrap=%b, expected all 0",
                     bus.leds, bus.step_tick, bus.wrap);
        end
        gotq.delete();
        wrapq.delete();
        for (int c = 0; c < 2 * DIV; c++) begin
            @(negedge clk);
            if (bus.step_tick) begin
                gotq.push_back(bus.leds);
                wrapq.push_back(bus.wrap);
            end
        end
        numChecks++;
        if (gotq.size() != 2 || gotq[0] !== 5'b00000 || wrapq[0] !== 1'b0 || gotq[1] !== 5'b00001) begin
            numErrors++;
            $display("[TB] FAIL after_reset: got %0d steps first=%b wrap=%b, expected steps 00000 (no wrap) then 00001",
                     gotq.size(), (gotq.size() > 0) ? gotq[0] : 5'bx, (wrapq.size() > 0) ? wrapq[0] : 1'bx);
        end
    endtask

    task automatic test_random();
        bus.mode   = CHASE_R;
        bus.speed  = 2'd0;
        bus.enable = 1'b1;
        doReset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            numChecks++;
            if ({bus.leds, bus.step_tick, bus.wrap} !== {m.leds, m.step, m.wrap}) begin
                numErrors++;
                $display("[TB] FAIL model_random cycle %0d: got leds=%b step=%b wrap=%b, expected leds=%b step=%b wrap=%b",
                         c, bus.leds, bus.step_tick, bus.wrap, m.leds, m.step, m.wrap);
            end
            reset      = ($urandom_range(199) == 0);
            bus.enable = ($urandom_range(7) != 0);
            if ($urandom_range(39) == 0) bus.mode = mode_e'($urandom_range(3));
            if ($urandom_range(59) == 0) bus.speed = 2'($urandom_range(3));
        end
        reset = 1'b0;
    endtask

    // Hard stop in case a wait never completes.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.mode   = CHASE_R;
        bus.speed  = 2'd0;
        test_reset();
        test_patterns();
        test_speed();
        test_pause();
        test_mode_change_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end
endmodule

// File: doc/seq_chaser.md
SEQ_CHASER -- requirements
Module: seq_chaser

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 5, giving the number of LED outputs; legal range 2..32.
REQ-002 The block SHALL have parameter TICK_DIV, default 1000000, giving the base step period in clk cycles; legal range 1..2^24.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = run, 0 = pause (prescaler and sequence frozen, outputs held).
REQ-006 mode  input  2  pattern: 0 CHASE_R, 1 CHASE_L, 2 BOUNCE, 3 FILL.
REQ-007 speed  input  2  step period = TICK_DIV << speed cycles.
REQ-008 leds  output  NUM_LEDS  registered LED pattern.
REQ-009 step_tick  output  1  registered one-cycle pulse in the cycle leds takes a new step value.
REQ-010 wrap  output  1  registered one-cycle pulse when the pattern restarts its cycle.

Function
REQ-011 The prescaler SHALL count 0..P-1 while enable=1, with P = TICK_DIV << speed; the internal tick is the cycle in which count >= P-1, and count returns to 0 on the following edge.
REQ-012 If speed changes so that count >= new P-1, the SHALL rule of REQ-011 applies immediately (tick that cycle, count to 0); no out-of-range counting.
REQ-013 With TICK_DIV=1 and speed=0, a tick SHALL occur every enabled cycle.
REQ-014 The sequencer states SHALL be BLANK, UP, DOWN with position pos in 0..NUM_LEDS-1; it advances only on ticks.
REQ-015 CHASE_R: BLANK -> UP pos 0 -> ... -> pos N-1 -> BLANK; leds = one-hot at bit pos, all-zero in BLANK; period N+1 ticks.
REQ-016 CHASE_L: same sequence as CHASE_R but leds = one-hot at bit N-1-pos.
REQ-017 BOUNCE: BLANK -> UP pos 0..N-1 -> DOWN pos N-2..0 -> UP pos 1 ...; BLANK only entered from reset or mode change; one-hot at pos.
REQ-018 FILL: same state sequence as CHASE_R; leds bits 0..pos all set, all-zero in BLANK.
REQ-019 Mode SHALL be latched at each tick; if mode differs from the latched mode, the sequencer SHALL go to BLANK on that tick and adopt the new mode from the next tick.
REQ-020 wrap SHALL pulse with the step entering BLANK (modes 0,1,3) or entering DOWN pos 0 (BOUNCE); not on mode-change-induced BLANK.
REQ-021 leds, step_tick and wrap SHALL update on the same edge that consumes a tick (one-cycle latency from tick).
REQ-022 enable=0 SHALL freeze count, state, pos and leds; step_tick and wrap SHALL be 0 while paused; resuming continues from the frozen count.

Reset
REQ-023 reset=1 at a rising edge SHALL set count=0, state BLANK, pos=0, latched mode=0, leds=0, step_tick=0, wrap=0, overriding enable and any tick in that cycle.
REQ-024 Reset mid-sequence SHALL restart with the first tick after release producing UP pos 0.

Structure
REQ-025 Package seq_chaser_pkg SHALL hold the mode enum (CHASE_R, CHASE_L, BOUNCE, FILL) and state enum (BLANK, UP, DOWN).
REQ-026 Prescaler counter width SHALL be $clog2(TICK_DIV*8)+1, computed locally; pos width $clog2(NUM_LEDS).
REQ-027 The prescaler SHALL be a sub-module chaser_prescaler (clk, reset, enable, speed -> tick); the sequencer and output decode live in seq_chaser.
REQ-028 Illegal NUM_LEDS or TICK_DIV SHALL fail elaboration.

Verification (NUM_LEDS=5, TICK_DIV=4)
REQ-029 reset, enable=1, mode=0, speed=0 -> ticks every 4 cycles; leds 00001,00010,00100,01000,10000,00000, wrap on the 00000 step.
REQ-030 mode=2 from reset -> leds positions 0,1,2,3,4,3,2,1,0,1; wrap with the second pos-0 step; never 00000 after first step.
REQ-031 mode=3 -> leds 00001,00011,00111,01111,11111,00000 repeating; mode=1 -> 10000,01000,00100,00010,00001,00000.
REQ-032 speed=2 -> step_tick every 16 cycles; change speed 2->0 when count=10 -> tick that cycle, then every 4.
REQ-033 enable=0 for 20 cycles mid-sequence -> leds, step_tick, wrap frozen/0; after resume next tick arrives after the remaining count.
REQ-034 mode 0->2 at pos 3, then reset asserted mid-pattern -> BLANK step with no wrap, then bounce from pos 0; reset -> all outputs 0 next edge.
